// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receiver config owner, frame-in-flight tracker, capture FIFO.
// Build option UART_RX_CTRL_DROP_ERR_EN: drop errored frames, count in err_count.
module uart_rx_ctrl #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int FIFO_DEPTH    = 4,
  parameter int RECONF_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_baud,
  input  logic [1:0] cfg_parity,
  input  logic       rx_line,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic [2:0] rx_error,
  output logic [1:0] baud_rate,
  output logic [1:0] parity_type,
  output logic       rx_reset_n,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [2:0] out_err,
  input  logic       out_ready,
  output logic       overflow,
  output logic       cfg_pending
`ifdef UART_RX_CTRL_DROP_ERR_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [17:0] RECONF_LD = 18'(RECONF_CYCLES);
  localparam logic [17:0] TO_2400   = 18'(12 * (CLK_HZ / 2400));
  localparam logic [17:0] TO_4800   = 18'(12 * (CLK_HZ / 4800));
  localparam logic [17:0] TO_9600   = 18'(12 * (CLK_HZ / 9600));
  localparam logic [17:0] TO_19200  = 18'(12 * (CLK_HZ / 19200));
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    RECONF = 2'd0,
    RUN    = 2'd1,
    BUSY   = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [17:0] cnt, cnt_nx;
  logic [17:0] timeout;
  logic [1:0]  pend_baud, pend_parity;
  logic        rx_prev, fall, apply;

  logic [10:0]   mem [FIFO_DEPTH];
  logic [10:0]   head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          live, push_req, full, pop, push_ok, drop;

  assign fall       = rx_prev & ~rx_line;
  assign rx_reset_n = (state != RECONF);
  assign live       = (state != RECONF);

  always_comb begin
    timeout = TO_9600;
    unique case (baud_rate)
      2'b00: timeout = TO_2400;
      2'b01: timeout = TO_4800;
      2'b10: timeout = TO_9600;
      2'b11: timeout = TO_19200;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    apply    = 1'b0;
    unique case (state)
      RECONF: begin
        cnt_nx = cnt - 18'd1;
        if (cnt <= 18'd1) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        // A starting frame always wins over a pending apply.
        if (fall) begin
          state_nx = BUSY;
          cnt_nx   = timeout;
        end else if (cfg_pending) begin
          apply    = 1'b1;
          state_nx = RECONF;
          cnt_nx   = RECONF_LD;
        end
      end
      BUSY: begin
        if (rx_done || cnt <= 18'd1) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 18'd1;
        end
      end
      default: begin
        state_nx = RECONF;
        cnt_nx   = RECONF_LD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RECONF;
      cnt         <= RECONF_LD;
      rx_prev     <= 1'b1;
      baud_rate   <= 2'b10;
      parity_type <= 2'b01;
      pend_baud   <= 2'b10;
      pend_parity <= 2'b01;
      cfg_pending <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rx_prev <= rx_line;
      if (apply) begin
        baud_rate   <= pend_baud;
        parity_type <= pend_parity;
      end
      if (cfg_wr) begin
        pend_baud   <= cfg_baud;
        pend_parity <= cfg_parity;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

`ifdef UART_RX_CTRL_DROP_ERR_EN
  assign push_req = rx_done & live & (rx_error == 3'b000);
`else
  assign push_req = rx_done & live;
`endif

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head[7:0] : 8'h00;
  assign out_err   = out_valid ? head[10:8] : 3'b000;
  assign full      = (count == FULL_CNT);
  assign pop       = out_valid & out_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {rx_error, rx_data};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef UART_RX_CTRL_DROP_ERR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err_count <= '0;
    end else if (rx_done && live && rx_error != 3'b000 &&
                 err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed plan scenarios plus random FIFO traffic
// checked against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int CLK   = 50_000_000;
  localparam int DEPTH = 4;
  localparam int RC    = 4;
  localparam int T9600 = 12 * (CLK / 9600);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_baud = 2'b00;
  logic [1:0] cfg_parity = 2'b00;
  logic       rx_line = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [2:0] rx_error = 3'b000;
  logic       out_ready = 1'b0;
  logic [1:0] baud_rate, parity_type;
  logic       rx_reset_n, out_valid, overflow, cfg_pending;
  logic [7:0] out_data;
  logic [2:0] out_err;
`ifdef UART_RX_CTRL_DROP_ERR_EN
  logic [7:0] err_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [10:0] mq[$];
  logic        m_ov, m_pop, m_full;
  int          m_err;
  int          k;
  logic [7:0]  drain_exp [4];

  uart_rx_ctrl #(
    .CLK_HZ(CLK), .FIFO_DEPTH(DEPTH), .RECONF_CYCLES(RC)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_wr(cfg_wr), .cfg_baud(cfg_baud), .cfg_parity(cfg_parity),
    .rx_line(rx_line), .rx_done(rx_done),
    .rx_data(rx_data), .rx_error(rx_error),
    .baud_rate(baud_rate), .parity_type(parity_type),
    .rx_reset_n(rx_reset_n),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
    .out_ready(out_ready), .overflow(overflow),
    .cfg_pending(cfg_pending)
`ifdef UART_RX_CTRL_DROP_ERR_EN
    , .err_count(err_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts clocks the receiver stays held in reset, from now on.
  task automatic count_low(input string tag);
    int low = 0;
    for (int i = 0; i < 20; i++) begin
      if (rx_reset_n) break;
      low++;
      tick();
    end
    check(tag, low, RC);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_rxn", rx_reset_n, 0);
    check("rst_baud", baud_rate, 2'b10);
    check("rst_par", parity_type, 2'b01);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_err", out_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_pend", cfg_pending, 0);
    reset = 1'b0;
    count_low("release");

    rx_done = 1'b1; rx_data = 8'hAA; rx_error = 3'b000;
    tick();
    rx_done = 1'b0;
    check("cap_valid", out_valid, 1);
    check("cap_data", out_data, 8'hAA);
    check("cap_err", out_err, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("cap_pop", out_valid, 0);

    for (int i = 1; i <= 5; i++) begin
      rx_done = 1'b1; rx_data = 8'(i);
      tick();
      check("ovf_flag", overflow, (i == 5) ? 1 : 0);
    end
    check("ovf_head", out_data, 8'd1);
    rx_data = 8'd6; out_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    check("full_pp_head", out_data, 8'd2);
    drain_exp = '{8'd2, 8'd3, 8'd4, 8'd6};
    for (int j = 0; j < 4; j++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, drain_exp[j]);
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    rx_line = 1'b0;
    tick();
    rx_line = 1'b1;
    cfg_wr = 1'b1; cfg_baud = 2'b00; cfg_parity = 2'b00;
    tick();
    cfg_baud = 2'b11; cfg_parity = 2'b10;
    tick();
    cfg_wr = 1'b0;
    check("defer_pend", cfg_pending, 1);
    check("defer_baud", baud_rate, 2'b10);
    repeat (3) tick();
    check("defer_hold", baud_rate, 2'b10);
    rx_done = 1'b1; rx_data = 8'h5A; rx_error = 3'b000;
    tick();
    rx_done = 1'b0;
    check("busy_cap", out_data, 8'h5A);
    check("defer_pre", baud_rate, 2'b10);
    tick();
    check("apply_baud", baud_rate, 2'b11);
    check("apply_par", parity_type, 2'b10);
    check("apply_pend", cfg_pending, 0);
    count_low("reconf1");
    check("reconf_keep", out_data, 8'h5A);

    cfg_wr = 1'b1; cfg_baud = 2'b10; cfg_parity = 2'b01;
    tick();
    check("quiet_pend", cfg_pending, 1);
    check("quiet_old", baud_rate, 2'b11);
    tick();
    cfg_wr = 1'b0;
    check("quiet_baud", baud_rate, 2'b10);
    check("quiet_par", parity_type, 2'b01);
    check("rewr_pend", cfg_pending, 1);
    count_low("reconf2");
    tick();
    check("reapply_rxn", rx_reset_n, 0);
    check("reapply_pend", cfg_pending, 0);
    count_low("reconf3");

    rx_line = 1'b0;
    tick();
    rx_line = 1'b1;
    cfg_wr = 1'b1; cfg_baud = 2'b01; cfg_parity = 2'b00;
    tick();
    cfg_wr = 1'b0;
    k = 1;
    while (baud_rate == 2'b10 && k < 70000) begin
      tick();
      k++;
    end
    check("timeout", k, T9600 + 1);
    check("to_par", parity_type, 2'b00);
    check("to_fifo", out_data, 8'h5A);
    count_low("reconf4");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("to_drain", out_valid, 0);

    rx_done = 1'b1; rx_data = 8'h33; rx_error = 3'b001;
    tick();
    rx_done = 1'b0;
`ifdef UART_RX_CTRL_DROP_ERR_EN
    check("drop_valid", out_valid, 0);
    check("drop_cnt", err_count, 1);
`else
    check("errf_valid", out_valid, 1);
    check("errf_err", out_err, 3'b001);
    check("errf_data", out_data, 8'h33);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    reset = 1'b1;
    tick();
    check("rerst_ovf", overflow, 0);
    check("rerst_baud", baud_rate, 2'b10);
    reset = 1'b0;
    count_low("release2");

    mq.delete();
    m_ov = 1'b0;
    m_err = 0;
    for (int i = 0; i < 400; i++) begin
      rx_done = ($urandom_range(0, 2) != 0);
      rx_data = 8'($urandom);
      rx_error = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'b000;
      out_ready = ($urandom_range(0, 3) < ((i < 200) ? 1 : 3));
      m_pop = (mq.size() != 0) && out_ready;
      m_full = (mq.size() == DEPTH);
      if (m_pop) void'(mq.pop_front());
`ifdef UART_RX_CTRL_DROP_ERR_EN
      if (rx_done && rx_error != 3'b000) begin
        if (m_err < 255) m_err++;
      end else
`endif
      if (rx_done) begin
        if (m_full && !m_pop) m_ov = 1'b1;
        else mq.push_back({rx_error, rx_data});
      end
      tick();
      check("rnd_valid", out_valid, (mq.size() != 0) ? 1 : 0);
      if (mq.size() != 0) begin
        check("rnd_data", out_data, mq[0][7:0]);
        check("rnd_err", out_err, mq[0][10:8]);
      end
      check("rnd_ovf", overflow, m_ov);
    end
    rx_done = 1'b0;
    out_ready = 1'b0;
`ifdef UART_RX_CTRL_DROP_ERR_EN
    check("rnd_errcnt", err_count, m_err);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver unit. Owns the receiver's `baud_rate` and `parity_type` settings and holds the receiver in reset while settings change. Defers configuration writes until no frame is in flight. Captures each completed frame (data plus error flags) into a small FIFO drained by a valid/ready consumer, and sits between the host register interface and the receiver unit.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency; used to size bit times.
- `FIFO_DEPTH`, 4: capture FIFO entries; must be a power of two, 2..16.
- `RECONF_CYCLES`, 4: clocks the receiver is held in reset on a configuration change; minimum 1.

Ports:
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cfg_wr` in 1: one-cycle configuration write strobe.
- `cfg_baud` in 2: baud code; 00=2400, 01=4800, 10=9600, 11=19200.
- `cfg_parity` in 2: parity code; 00=none, 01=odd, 10=even, 11=none.
- `rx_line` in 1: serial line, already synchronised; idles high.
- `rx_done` in 1: one-cycle pulse from the receiver when a frame completes.
- `rx_data` in 8: receiver `Data`; valid when `rx_done`=1.
- `rx_error` in 3: receiver `error_flag`; valid when `rx_done`=1; nonzero means an errored frame.
- `baud_rate` out 2: to the receiver.
- `parity_type` out 2: to the receiver.
- `rx_reset_n` out 1: active-low reset to the receiver's `reset_n`.
- `out_valid` out 1: FIFO head is valid.
- `out_data` out 8: FIFO head data.
- `out_err` out 3: FIFO head error flags.
- `out_ready` in 1: consumer accepts the head.
- `overflow` out 1: sticky; a frame was lost because the FIFO was full.
- `cfg_pending` out 1: a configuration write is waiting to be applied.

## Operation

**Reset values** (when `reset`=1):
- `baud_rate`=2'b10, `parity_type`=2'b01.
- `rx_reset_n`=0.
- FIFO empty; `out_valid`=0, `out_data`=0, `out_err`=0.
- `overflow`=0, `cfg_pending`=0.
- State RECONF with the cycle counter loaded to `RECONF_CYCLES`. The receiver is therefore released `RECONF_CYCLES` clocks after `reset` deasserts.

**States:**
- RUN
  - `rx_reset_n`=1.
  - A falling edge on `rx_line` (previous sample 1, current 0) goes to BUSY and loads the timeout counter.
  - If `cfg_pending`=1 and no falling edge occurs this cycle: apply the pending settings, load the cycle counter to `RECONF_CYCLES`, go to RECONF.
- BUSY (frame in flight)
  - Leave for RUN on `rx_done` or on timeout expiry.
  - Timeout = 12 bit times = 12*(CLK_HZ/baud), integer division, for the current `baud_rate`; counter width 18 bits.
  - Timeout expiry pushes nothing.
- RECONF
  - `rx_reset_n`=0 while the counter counts down; go to RUN when it reaches 0.
  - `rx_line` edges and `rx_done` are ignored.

**Configuration writes:**
- `cfg_wr` in any state latches `cfg_baud`/`cfg_parity` into a pending register and sets `cfg_pending`.
- A later write before apply overwrites the pending values (last write wins).
- `cfg_pending` clears in the same cycle the settings are applied.
- `cfg_wr` in the apply cycle: the new values become pending again and `cfg_pending` stays 1.

**FIFO:**
- Push `{rx_error, rx_data}` on `rx_done` in RUN or BUSY.
- Pop when `out_valid && out_ready`.
- Outputs are driven from the head register (no combinational path from `rx_*` to `out_*`).
- Push and pop in the same cycle, FIFO full: both succeed and the count is unchanged.
- Push to a full FIFO without a same-cycle pop: frame dropped, `overflow` set.
- `overflow` clears only on `reset`.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. A count of FIFO_DEPTH+1 values distinguishes full from empty.
- FIFO contents survive RECONF.

## Timing
- `rx_done` at cycle N: `out_valid`=1 at N+1 if the FIFO was empty.
- Pop at cycle N: the next entry is on `out_*` at N+1.
- Apply cycle N: new `baud_rate`/`parity_type` and `rx_reset_n`=0 at N+1; `rx_reset_n`=1 at N+1+RECONF_CYCLES.
- `cfg_wr` in RUN with a quiet line: applied one cycle later.
- `rx_done` arriving in RUN (no edge seen) is still captured.

## Configuration
- `UART_RX_CTRL_DROP_ERR_EN`
  - Defined: frames with `rx_error`≠0 are not pushed. An 8-bit saturating counter `err_count` (extra output port) increments per dropped frame and resets to 0.
  - Undefined: every frame is pushed with its error flags; no `err_count` port.

## Test plan
- Reset release: `rx_reset_n`=0 for exactly 4 clocks after `reset` falls; `baud_rate`=10, `parity_type`=01.
- Frame capture: `rx_done` with `rx_data`=8'hAA, `rx_error`=0, `out_ready`=0 → next cycle `out_valid`=1, `out_data`=AA; `out_ready`=1 one cycle → `out_valid`=0.
- Deferred config: falling `rx_line` then `cfg_wr` (baud 11, parity 10) → `cfg_pending`=1, `baud_rate` unchanged until `rx_done`; one cycle later `baud_rate`=11, `rx_reset_n` low 4 clocks.
- Timeout: falling edge, no `rx_done` at baud 10 → return to RUN after 62496 clocks, FIFO unchanged.
- Overflow: 5 `rx_done` pulses (data 1..5), `out_ready`=0, depth 4 → `overflow`=1, drained order 1,2,3,4; simultaneous push+pop when full keeps count 4.
- Macro: with `UART_RX_CTRL_DROP_ERR_EN`, `rx_done` with `rx_error`=3'b001 → no `out_valid`, `err_count`=1; without it → `out_err`=001.
